pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready_o.
module pipe_stage_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic              accept;
  logic              drain;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = main_valid & out_ready_i;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready_o = ~skid_valid;

  // Main and skid entries; skid refills main whenever main frees up.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_ctrl  <= ctrl_i;
        main_data  <= data_i;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= ctrl_i;
      skid_data  <= data_i;
    end
  end
`else
  assign in_ready_o = ~main_valid | out_ready_i;

  // Single entry: load on accept, empty out on a drain with no refill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_ctrl  <= ctrl_i;
      main_data  <= data_i;
    end else if (drain) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end
  end
`endif

  // Saturating count of cycles where a valid entry is held back.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid_o = main_valid;
  assign ctrl_o      = main_ctrl;
  assign data_o      = main_data;
  assign stall_cnt_o = stall_cnt;

endmodule
